bcd_convert_sched: RTL and testbench

Multi-cycle sequencer that shares a small bank of per-digit BCD converters across a wide packed BCD word. It accepts a NUM_DIGITS-digit BCD word over a valid/ready handshake and converts LANES digits per clock into 10-bit decimal fields. It flags and counts invalid codes (>9), then presents the full result over a second valid/ready handshake. It sits in front of the wide combinational BCD-to-decimal datapath and replaces it where area matters more than latency.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_convert_sched_if.sv | 33 +++
 rtl/bcd_digit_lane.sv | 21 ++
 rtl/bcd_convert_sched.sv | 157 +++++++++++++++
 tb/tb_bcd_convert_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the time-multiplexed BCD-to-decimal converter.
//   BCD_W / DEC_W     : width of one packed BCD digit / one decimal output field
//   state_e           : sequencer states
//   dec_res_t         : per-digit conversion result {invalid, value}
//   bcd_digit_to_dec  : converts one BCD code; codes above 9 give value 0 and invalid=1
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned DEC_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic             invalid;
        logic [DEC_W-1:0] value;
    } dec_res_t;

    function automatic dec_res_t bcd_digit_to_dec(input logic [BCD_W-1:0] digit);
        dec_res_t res;
        res.invalid = (digit > BCD_W'(9));
        res.value   = res.invalid ? '0 : DEC_W'(digit);
        return res;
    endfunction

endpackage

// File: rtl/bcd_convert_sched_if.sv
// Word-in / result-out handshake bundle for bcd_convert_sched.
//   in_valid/in_ready/in_bcd          : input word handshake (packed BCD, digit i at [4i+3:4i])
//   out_valid/out_ready               : result handshake
//   out_dec/out_err/out_err_count     : decimal fields, invalid-digit flag and count
// master = word producer / result consumer, slave = the scheduler.
interface bcd_convert_sched_if
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 300
) ();

    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic [BCD_W*NUM_DIGITS-1:0] in_bcd;
    logic                        out_valid;
    logic                        out_ready;
    logic [DEC_W*NUM_DIGITS-1:0] out_dec;
    logic                        out_err;
    logic [CW-1:0]               out_err_count;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_dec, out_err, out_err_count
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_dec, out_err, out_err_count
    );

endinterface

// File: rtl/bcd_digit_lane.sv
// One combinational BCD digit converter lane.
//   digit     : 4-bit BCD code
//   dec_c     : 10-bit decimal value (0 for invalid codes)
//   invalid_c : code was 10..15
module bcd_digit_lane
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [DEC_W-1:0] dec_c,
    output logic             invalid_c
);

    dec_res_t res;

    always_comb begin
        res       = bcd_digit_to_dec(digit);
        dec_c     = res.value;
        invalid_c = res.invalid;
    end

endmodule

// File: rtl/bcd_convert_sched.sv
// Converts a wide packed BCD word LANES digits per cycle using a shared bank of
// digit lanes, accumulating an invalid-digit count, then presents the result.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous abort of any job in progress
//   busy         : sequencer not idle
//   bus          : word input and result output handshakes (slave side)
module bcd_convert_sched
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 300,
    parameter int unsigned LANES      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    output logic                busy,
    bcd_convert_sched_if.slave  bus
);

    localparam int unsigned NCHUNK = (NUM_DIGITS + LANES - 1) / LANES;
    localparam int unsigned CW     = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;
    // Word register padded to whole chunks so the lanes always read in range.
    localparam int unsigned WW     = BCD_W * NCHUNK * LANES;
    localparam int unsigned RW     = DEC_W * NUM_DIGITS;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]    state_q,     state_d;
    logic [IW-1:0] idx_q,       idx_d;
    logic [WW-1:0] word_q,      word_d;
    logic [RW-1:0] dec_q,       dec_d;
    logic          err_q,       err_d;
    logic [CW-1:0] err_cnt_q,   err_cnt_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q,      busy_d;

    logic [LANES-1:0][DEC_W-1:0] lane_dec;
    logic [LANES-1:0]            lane_inv;
    logic [LANES-1:0]            lane_ok;
    logic [CW-1:0]               err_inc;

    // Lane k always sees the lowest digits of the word register; it shifts down one chunk per RUN cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bcd_digit_lane u_lane (
            .digit     (word_q[k*BCD_W +: BCD_W]),
            .dec_c     (lane_dec[k]),
            .invalid_c (lane_inv[k])
        );
    end

    // Mask padding lanes of the partial last chunk and sum the real invalid flags.
    always_comb begin
        lane_ok = '0;
        err_inc = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_ok[k] = ((32'(idx_q) * LANES + 32'(k)) < NUM_DIGITS);
            if (lane_ok[k] && lane_inv[k]) begin
                err_inc = err_inc + CW'(1);
            end
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        dec_d     = dec_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        if (flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        word_d    = WW'(bus.in_bcd);
                        dec_d     = '0;
                        err_d     = 1'b0;
                        err_cnt_d = '0;
                        idx_d     = '0;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Chunk demux: digit i belongs to chunk i/LANES, lane i%LANES.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (idx_q == IW'(32'(i) / LANES)) begin
                            dec_d[i*DEC_W +: DEC_W] = lane_dec[LW'(32'(i) % LANES)];
                        end
                    end
                    word_d    = word_q >> (BCD_W * LANES);
                    err_cnt_d = err_cnt_q + err_inc;
                    err_d     = err_q | (|(lane_inv & lane_ok));
                    if (idx_q == IW'(NCHUNK - 1)) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            dec_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            dec_q       <= dec_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_dec       = dec_q;
    assign bus.out_err       = err_q;
    assign bus.out_err_count = err_cnt_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Randomised self-checking bench: a 300-digit/4-lane instance and a
// 10-digit/4-lane instance (partial last chunk) against a digit-by-digit model.
module tb_bcd_convert_sched;

    localparam int BN   = 300;
    localparam int BNCH = 75;
    localparam int BCW  = 9;
    localparam int SN   = 10;
    localparam int SNCH = 3;
    localparam int SCW  = 4;

    logic clk;
    logic rst_n;
    logic b_flush, b_busy;
    logic s_flush, s_busy;

    int n_checks;
    int n_fail;

    bcd_convert_sched_if #(.NUM_DIGITS(BN)) b_if ();
    bcd_convert_sched_if #(.NUM_DIGITS(SN)) s_if ();

    bcd_convert_sched #(.NUM_DIGITS(BN), .LANES(4)) u_big (
        .clk     (clk),
        .reset_n (rst_n),
        .flush   (b_flush),
        .busy    (b_busy),
        .bus     (b_if.slave)
    );

    bcd_convert_sched #(.NUM_DIGITS(SN), .LANES(4)) u_small (
        .clk     (clk),
        .reset_n (rst_n),
        .flush   (s_flush),
        .busy    (s_busy),
        .bus     (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: each BCD digit maps to its own value, codes above 9 to 0 and count as errors.
    function automatic logic [10*BN-1:0] model_big(input logic [4*BN-1:0] w, output int ecnt);
        logic [10*BN-1:0] r;
        int dg;
        r    = '0;
        ecnt = 0;
        for (int i = 0; i < BN; i++) begin
            dg = int'(w[4*i +: 4]);
            if (dg <= 9) r[10*i +: 10] = 10'(dg);
            else         ecnt++;
        end
        return r;
    endfunction

    function automatic logic [10*SN-1:0] model_small(input logic [4*SN-1:0] w, output int ecnt);
        logic [10*SN-1:0] r;
        int dg;
        r    = '0;
        ecnt = 0;
        for (int i = 0; i < SN; i++) begin
            dg = int'(w[4*i +: 4]);
            if (dg <= 9) r[10*i +: 10] = 10'(dg);
            else         ecnt++;
        end
        return r;
    endfunction

    function automatic int bad_big(input logic [10*BN-1:0] got, input logic [10*BN-1:0] exp);
        int n = 0;
        for (int i = 0; i < BN; i++) if (got[10*i +: 10] !== exp[10*i +: 10]) n++;
        return n;
    endfunction

    function automatic int bad_small(input logic [10*SN-1:0] got, input logic [10*SN-1:0] exp);
        int n = 0;
        for (int i = 0; i < SN; i++) if (got[10*i +: 10] !== exp[10*i +: 10]) n++;
        return n;
    endfunction

    function automatic logic [4*BN-1:0] rand_word_big(input int inv_one_in);
        logic [4*BN-1:0] w;
        for (int i = 0; i < BN; i++) begin
            if ($urandom_range(inv_one_in - 1, 0) == 0) w[4*i +: 4] = 4'($urandom_range(15, 10));
            else                                          w[4*i +: 4] = 4'($urandom_range(9, 0));
        end
        return w;
    endfunction

    function automatic logic [4*BN-1:0] fill_big(input logic [3:0] d);
        logic [4*BN-1:0] w;
        for (int i = 0; i < BN; i++) w[4*i +: 4] = d;
        return w;
    endfunction

    // Full transaction on the large instance; entered and left at #1 after an edge in IDLE.
    task automatic big_job(input logic [4*BN-1:0] w, input int stall, input string tag);
        logic [10*BN-1:0] exp_dec;
        int ecnt, n, unstable;
        exp_dec = model_big(w, ecnt);
        check_eq({tag, "_in_ready"}, 32'(b_if.in_ready), 1);
        b_if.in_valid = 1'b1;
        b_if.in_bcd   = w;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        b_if.in_bcd   = rand_word_big(2);
        check_eq({tag, "_busy"}, 32'(b_busy), 1);
        n = 0;
        while (b_if.out_valid !== 1'b1 && n < BNCH + 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, n, BNCH);
        check_eq({tag, "_dec_bad_fields"}, bad_big(b_if.out_dec, exp_dec), 0);
        check_eq({tag, "_err"}, 32'(b_if.out_err), (ecnt > 0) ? 1 : 0);
        check_eq({tag, "_err_count"}, 32'(b_if.out_err_count), ecnt);
        unstable = 0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (b_if.out_valid !== 1'b1 || b_if.in_ready !== 1'b0 ||
                b_if.out_err_count !== BCW'(ecnt) || bad_big(b_if.out_dec, exp_dec) != 0)
                unstable++;
        end
        if (stall > 0) check_eq({tag, "_stall_unstable_cycles"}, unstable, 0);
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        b_if.out_ready = 1'b0;
        check_eq({tag, "_out_valid_after"}, 32'(b_if.out_valid), 0);
        check_eq({tag, "_in_ready_after"}, 32'(b_if.in_ready), 1);
    endtask

    task automatic small_job(input logic [4*SN-1:0] w, input string tag);
        logic [10*SN-1:0] exp_dec;
        int ecnt, n;
        exp_dec = model_small(w, ecnt);
        s_if.in_valid = 1'b1;
        s_if.in_bcd   = w;
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        s_if.in_bcd   = 40'($urandom) ^ (40'($urandom) << 20);
        n = 0;
        while (s_if.out_valid !== 1'b1 && n < SNCH + 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, n, SNCH);
        check_eq({tag, "_dec_bad_fields"}, bad_small(s_if.out_dec, exp_dec), 0);
        check_eq({tag, "_err_count"}, 32'(s_if.out_err_count), ecnt);
        check_eq({tag, "_err"}, 32'(s_if.out_err), (ecnt > 0) ? 1 : 0);
        s_if.out_ready = 1'b1;
        @(posedge clk); #1;
        s_if.out_ready = 1'b0;
        check_eq({tag, "_in_ready_after"}, 32'(s_if.in_ready), 1);
    endtask

    initial begin
        logic [4*BN-1:0] w;
        logic [4*SN-1:0] sw;
        int seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        b_flush = 1'b0; s_flush = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_bcd = '0; b_if.out_ready = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_bcd = '0; s_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check_eq("rst_in_ready", 32'(b_if.in_ready), 1);
        check_eq("rst_out_valid", 32'(b_if.out_valid), 0);
        check_eq("rst_busy", 32'(b_busy), 0);
        check_eq("rst_err", 32'(b_if.out_err), 0);
        check_eq("rst_err_count", 32'(b_if.out_err_count), 0);
        check_eq("rst_dec_nonzero", bad_big(b_if.out_dec, '0), 0);

        big_job(fill_big(4'd7), 0, "all7");

        w = fill_big(4'd3);
        w[4*5 +: 4] = 4'hC; w[4*17 +: 4] = 4'hC; w[4*299 +: 4] = 4'hC;
        big_job(w, 0, "three_bad");

        big_job(rand_word_big(8), 20, "stall20");
        for (int j = 0; j < 3; j++) big_job(rand_word_big(6), $urandom_range(5, 0), "rand");
        big_job(fill_big(4'hF), 1, "all_invalid");

        // Partial last chunk on the small instance.
        for (int i = 0; i < SN; i++) sw[4*i +: 4] = 4'(i);
        small_job(sw, "small_0to9");
        sw[4*9 +: 4] = 4'hE; sw[4*8 +: 4] = 4'hA;
        small_job(sw, "small_tail_bad");
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < SN; i++) sw[4*i +: 4] = 4'($urandom);
            small_job(sw, "small_rand");
        end

        // Abort mid-job at chunk 40: no result may appear.
        b_if.in_valid = 1'b1; b_if.in_bcd = rand_word_big(4);
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1 b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        check_eq("flush_busy", 32'(b_busy), 0);
        check_eq("flush_in_ready", 32'(b_if.in_ready), 1);
        seen = 0;
        for (int c = 0; c < BNCH + 10; c++) begin
            @(posedge clk); #1;
            if (b_if.out_valid === 1'b1) seen++;
        end
        check_eq("flush_out_valid_seen", seen, 0);
        b_flush = 1'b1; b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0; b_if.in_valid = 1'b0;
        check_eq("flush_idle_no_accept", 32'(b_busy), 0);
        big_job(fill_big(4'd1), 0, "after_flush");

        // Asynchronous reset mid-job.
        b_if.in_valid = 1'b1; b_if.in_bcd = rand_word_big(3);
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(b_if.out_valid), 0);
        check_eq("mid_rst_busy", 32'(b_busy), 0);
        check_eq("mid_rst_err", 32'(b_if.out_err), 0);
        check_eq("mid_rst_err_count", 32'(b_if.out_err_count), 0);
        check_eq("mid_rst_dec_nonzero", bad_big(b_if.out_dec, '0), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 32'(b_if.in_ready), 1);
        seen = 0;
        for (int c = 0; c < BNCH + 5; c++) begin
            @(posedge clk); #1;
            if (b_if.out_valid === 1'b1) seen++;
        end
        check_eq("post_rst_no_stale_result", seen, 0);
        big_job(rand_word_big(5), 2, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
